// File: rtl/fsub_pipe.sv
// Three-stage binary32 subtractor (y = x1 - x2), round toward zero, subnormals flushed.
// Valid/ready on both ports; each stage stalls in place when the consumer is not ready.
module fsub_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  logic        s1_valid, s2_valid, s3_valid;
  logic        s1_load, s2_load, s3_load;

  logic        s1_sign, s1_sub, s1_zsign;
  logic [7:0]  s1_exp;
  logic [26:0] s1_big, s1_small;

  logic        s2_sign, s2_zsign;
  logic [7:0]  s2_exp;
  logic [27:0] s2_sum;

  logic        a_sign, b_sign, a_zero, b_zero, swap, big_sign;
  logic [30:0] a_mag, b_mag;
  logic [23:0] a_man, b_man, big_man, small_man;
  logic [7:0]  big_exp, small_exp, shift_amt;
  logic [26:0] small_full, small_mask, small_aligned;

  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  exp_adj;
  logic [22:0] frac;
  logic [31:0] result;

  // A stage loads when it is empty or its current content moves on this cycle.
  assign s3_load   = s2_valid & (~s3_valid | out_ready);
  assign s2_load   = s1_valid & (~s2_valid | s3_load);
  assign in_ready  = ~s1_valid | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s3_valid;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load)      s2_valid <= 1'b1;
      else if (s3_load) s2_valid <= 1'b0;
      if (s3_load)                     s3_valid <= 1'b1;
      else if (s3_valid && out_ready)  s3_valid <= 1'b0;
    end
  end

  // S1: the subtrahend is negated so the rest of the datapath is a signed add.
  always_comb begin
    a_sign    = x1[31];
    b_sign    = ~x2[31];
    a_zero    = (x1[30:23] == 8'd0);
    b_zero    = (x2[30:23] == 8'd0);
    a_mag     = a_zero ? 31'd0 : x1[30:0];
    b_mag     = b_zero ? 31'd0 : x2[30:0];
    a_man     = a_zero ? 24'd0 : {1'b1, x1[22:0]};
    b_man     = b_zero ? 24'd0 : {1'b1, x2[22:0]};
    swap      = (b_mag > a_mag);
    big_sign  = swap ? b_sign : a_sign;
    big_exp   = swap ? b_mag[30:23] : a_mag[30:23];
    small_exp = swap ? a_mag[30:23] : b_mag[30:23];
    big_man   = swap ? b_man : a_man;
    small_man = swap ? a_man : b_man;
    shift_amt = big_exp - small_exp;
    small_full    = {small_man, 3'b000};
    small_mask    = 27'd0;
    small_aligned = {26'd0, |small_man};
    if (shift_amt < 8'd26) begin
      small_mask    = (27'd1 << shift_amt[4:0]) - 27'd1;
      small_aligned = (small_full >> shift_amt[4:0]) | {26'd0, |(small_full & small_mask)};
    end
  end

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                 : ({1'b0, s1_big} + {1'b0, s1_small});
  end

  // S3: a carry out renormalises right by one, otherwise left by the leading-zero count.
  always_comb begin
    lz = lzc27(s2_sum[26:0]);
    if (s2_sum[27]) begin
      exp_adj = {2'b00, s2_exp} + 10'd1;
      frac    = 23'(s2_sum >> 4);
    end else begin
      exp_adj = {2'b00, s2_exp} - {5'd0, lz};
      frac    = 23'((s2_sum[26:0] << lz) >> 3);
    end
    if (s2_sum == 28'd0)
      result = {s2_zsign, 31'd0};
    else if (exp_adj[9] || exp_adj == 10'd0)
      result = {s2_sign, 31'd0};
    else if (exp_adj > 10'd254)
      result = {s2_sign, 31'h7F7FFFFF};
    else
      result = {s2_sign, exp_adj[7:0], frac};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_zsign <= 1'b0;
      s1_exp   <= 8'd0;
      s1_big   <= 27'd0;
      s1_small <= 27'd0;
      s2_sign  <= 1'b0;
      s2_zsign <= 1'b0;
      s2_exp   <= 8'd0;
      s2_sum   <= 28'd0;
      y        <= 32'd0;
    end else begin
      if (s1_load) begin
        s1_sign  <= big_sign;
        s1_sub   <= a_sign ^ b_sign;
        s1_zsign <= a_sign & b_sign;
        s1_exp   <= big_exp;
        s1_big   <= {big_man, 3'b000};
        s1_small <= small_aligned;
      end
      if (s2_load) begin
        s2_sign  <= s1_sign;
        s2_zsign <= s1_zsign;
        s2_exp   <= s1_exp;
        s2_sum   <= sum;
      end
      if (s3_load) y <= result;
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
// Bench for fsub_pipe: directed vector table, backpressure and reset sequences,
// then randomized traffic scored against an exact-arithmetic reference model.
module tb_fsub_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x1, x2, y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_y;
    string       name;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fsub_pipe dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic r);
    in_valid  = v;
    x1        = a;
    x2        = b;
    out_ready = r;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] f);
    logic [10:0] de;
    de = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], de, f[22:0], 29'd0});
  endfunction

  // Exact difference via double-precision TwoSum, then truncated to binary32.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nb, r;
    logic [63:0] sbits;
    logic        sg;
    real         ra, rb, s, bb, err;
    int          fe;
    nb = {~b[31], b[30:0]};
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & nb[31], 31'd0};
    ra = (a[30:23] == 8'd0) ? 0.0 : to_real(a);
    rb = (b[30:23] == 8'd0) ? 0.0 : to_real(nb);
    s  = ra + rb;
    if (s == 0.0) return 32'd0;
    bb    = s - ra;
    err   = (ra - (s - bb)) + (rb - bb);
    sbits = $realtobits(s);
    sg    = sbits[63];
    fe    = int'(sbits[62:52]) - 896;
    if (fe >= 255) return {sg, 31'h7F7FFFFF};
    if (fe <= 0) return {sg, 31'd0};
    r = {sg, fe[7:0], sbits[51:29]};
    if (sbits[28:0] == 29'd0 && err != 0.0 && ((err < 0.0) != sg)) begin
      r[30:0] = r[30:0] - 31'd1;
      if (r[30:23] == 8'd0) r = {sg, 31'd0};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_partner(input logic [31:0] a);
    int sel, e;
    sel = int'($urandom_range(0, 9));
    e   = int'(a[30:23]) + int'($urandom_range(0, 4)) - 2;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    if (sel < 4) return {1'($urandom), 8'(e), 23'($urandom)};
    if (sel == 4) return {1'($urandom), a[30:0]};
    if (sel == 5) return {1'($urandom), a[30:1], ~a[0]};
    if (sel == 6) return {1'($urandom), 8'd0, 23'($urandom)};
    return rand_operand();
  endfunction

  // Idle pipeline, out_ready high: accept one pair and require the result two edges later.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string name);
    @(posedge clk); #1 apply_stimulus(1'b1, a, b, 1'b1);
    @(negedge clk);
    check_output({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_output({name, " early valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check_output({name, " y"}, y, exp);
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] ops_a[5], ops_b[5], exp_v[5];
    logic [31:0] y_hold;
    int          k, idx;
    for (int i = 0; i < 5; i++) begin
      ops_a[i] = rand_operand();
      ops_b[i] = rand_partner(ops_a[i]);
      exp_v[i] = ref_sub(ops_a[i], ops_b[i]);
    end
    k = 0;
    for (int c = 0; c < 6; c++) begin
      idx = (k < 5) ? k : 0;
      @(posedge clk); #1 apply_stimulus(k < 5, ops_a[idx], ops_b[idx], 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) k++;
    end
    check_output("bp accepted", 32'(k), 32'd3);
    check_output("bp in_ready", {31'd0, in_ready}, 32'd0);
    check_output("bp out_valid", {31'd0, out_valid}, 32'd1);
    y_hold = y;
    @(posedge clk);
    @(negedge clk);
    check_output("bp y stable", y, y_hold);
    for (int c = 0; c < 5; c++) begin
      idx = (k < 5) ? k : 0;
      @(posedge clk); #1 apply_stimulus(k < 5, ops_a[idx], ops_b[idx], 1'b1);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      check_output($sformatf("bp valid %0d", c), {31'd0, out_valid}, 32'd1);
      check_output($sformatf("bp y %0d", c), y, exp_v[c]);
    end
    @(posedge clk); #1 apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check_output("bp drained", {31'd0, out_valid}, 32'd0);
    check_output("bp all accepted", 32'(k), 32'd5);
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(posedge clk); #1 apply_stimulus(1'b1, 32'h40400000, 32'h3F800000, 1'b0);
    @(posedge clk); #1 apply_stimulus(1'b1, 32'h3F800000, 32'hBF800000, 1'b0);
    @(posedge clk); #1 apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_output("rst pre valid", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    check_output("rst valid", {31'd0, out_valid}, 32'd0);
    check_output("rst y", y, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_output("rst stale results", 32'(seen), 32'd0);
    run_single(32'h40400000, 32'h3F800000, 32'h40000000, "rst new op");
  endtask

  task automatic test_random(input int n_cycles);
    logic [31:0] a, b, hold_y;
    logic        hold;
    int          accepted, results;
    hold = 1'b0;
    hold_y = 32'd0;
    accepted = 0;
    results = 0;
    for (int c = 0; c < n_cycles; c++) begin
      a = rand_operand();
      b = rand_partner(a);
      @(posedge clk);
      #1 apply_stimulus($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0);
      @(negedge clk);
      if (hold) begin
        check_output("rand hold y", y, hold_y);
        check_output("rand hold valid", {31'd0, out_valid}, 32'd1);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(x1, x2));
        accepted++;
      end
      if (out_valid && out_ready) begin
        results++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rand spurious: got result %08h, expected none", y);
        end else begin
          check_output("rand y", y, exp_q.pop_front());
        end
      end
      hold   = out_valid && !out_ready;
      hold_y = y;
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1 apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      if (out_valid) begin
        results++;
        check_output("drain y", y, exp_q.pop_front());
      end
    end
    check_output("rand pending", 32'(exp_q.size()), 32'd0);
    check_output("rand count", 32'(results), 32'(accepted));
  endtask

  initial begin
    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, "3-1"};
    vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, "1-(-1)"};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, "1-1"};
    vecs[3]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, "1-2"};
    vecs[4]  = '{32'h3F800001, 32'h3F800000, 32'h34000000, "cancel"};
    vecs[5]  = '{32'h3F800000, 32'h33000000, 32'h3F7FFFFF, "sticky trunc"};
    vecs[6]  = '{32'h3F800000, 32'h00400000, 32'h3F800000, "subnormal"};
    vecs[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, "0-0"};
    vecs[8]  = '{32'h80000000, 32'h00000000, 32'h80000000, "-0-0"};
    vecs[9]  = '{32'h00000000, 32'h80000000, 32'h00000000, "0-(-0)"};
    vecs[10] = '{32'h80000000, 32'h80000000, 32'h00000000, "-0-(-0)"};
    vecs[11] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F7FFFFF, "overflow+"};
    vecs[12] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, "overflow-"};
    vecs[13] = '{32'h00800001, 32'h00800000, 32'h00000000, "underflow+"};
    vecs[14] = '{32'h00800000, 32'h00800001, 32'h80000000, "underflow-"};
    vecs[15] = '{32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, "shift 24"};
    vecs[16] = '{32'h4C800000, 32'h3F800000, 32'h4C7FFFFF, "shift 26"};
    vecs[17] = '{32'h80400000, 32'h00000000, 32'h80000000, "-sub-0"};

    rstn = 1'b0;
    apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check_output("reset out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset y", y, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_output("reset in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 18; i++)
      run_single(vecs[i].a, vecs[i].b, vecs[i].exp_y, vecs[i].name);

    test_backpressure();
    test_reset_midflight();
    test_random(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
